// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // RUN : nothing outstanding
  // WAIT: one request outstanding, its response will be buffered
  // DROP: one request outstanding, its response will be thrown away
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int ILEN_BYTES = 4;
  localparam int INSTR_W    = 32;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/grant/response channel plus the valid/ready channel to decode.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               imem_req;
  logic [WIDTH-1:0]   imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               if_valid;
  logic               if_ready;
  logic [WIDTH-1:0]   if_pc;
  logic [INSTR_W-1:0] if_instr;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   occ_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [AW:0]             occ_q;
  logic                    do_push, do_pop;

  assign do_push = push_i && (occ_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (occ_q != '0);

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage; cleared only by reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC register, issues one memory request at a
// time and buffers returned words for decode; redirects kill in-flight work.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             pc_en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  fetch_unit_if.master     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + INSTR_W;

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [AW:0]      occ;
  logic [EW-1:0]    head;
  logic             push, credit_ok, req, grant, pop;
  logic             unused_rpc;

  // Low redirect bits are dropped by the alignment.
  assign unused_rpc = ^redirect_pc[1:0];

  // A live response is pushed unless a redirect kills it this cycle.
  assign push = !rst && (state_q == WAIT) && bus.imem_rvalid && !redirect_valid;

  // Credit counts the word landing this cycle but not a concurrent pop, so a
  // granted request always has a free slot when its response returns.
  assign credit_ok = ({1'b0, occ} + (AW+2)'(push)) < (AW+2)'(DEPTH);

  // Request, PC update and next-state selection.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    pc_en    = 1'b0;
    next_pc  = pc;
    req      = !rst && !redirect_valid && credit_ok &&
               ((state_q == RUN) || ((state_q == WAIT) && bus.imem_rvalid));
    grant    = req && bus.imem_gnt;

    if (rst) begin
      next_pc = '0;
    end else if (redirect_valid) begin
      pc_en   = 1'b1;
      next_pc = {redirect_pc[WIDTH-1:2], 2'b00};
    end else if (grant) begin
      pc_en    = 1'b1;
      next_pc  = pc + WIDTH'(ILEN_BYTES);
      req_pc_d = pc;
    end

    case (state_q)
      RUN: begin
        if (grant) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid)        state_d = bus.imem_rvalid ? RUN : DROP;
        else if (bus.imem_rvalid)  state_d = grant ? WAIT : RUN;
      end
      DROP: begin
        // The killed response retires the outstanding slot even if another
        // redirect arrives alongside it; otherwise nothing would ever end DROP.
        if (bus.imem_rvalid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state and captured request PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign pop = bus.if_valid && bus.if_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({req_pc_q, bus.imem_rdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .occ_o   (occ)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = !rst && (occ != '0);
  assign bus.if_pc     = head[EW-1:INSTR_W];
  assign bus.if_instr  = head[INSTR_W-1:0];

endmodule
